// File: rtl/fp_addsub_issue.sv
// FADD.S/FSUB.S issue/retire stage: request FIFO in front of the external
// combinational adder, IEEE special-case resolution, registered writeback.
module fp_addsub_issue #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_op,
    input  logic [31:0]                req_a,
    input  logic [31:0]                req_b,
    input  logic [TAGW-1:0]            req_rd,
    output logic                       add_fpop,
    output logic [31:0]                add_data1,
    output logic [31:0]                add_data2,
    input  logic [31:0]                add_result,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [TAGW-1:0]            wb_rd,
    output logic [31:0]                wb_data,
    output logic [1:0]                 wb_flags,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic            mem_op [DEPTH];
    logic [31:0]     mem_a  [DEPTH];
    logic [31:0]     mem_b  [DEPTH];
    logic [TAGW-1:0] mem_rd [DEPTH];

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          empty, push, pop;

    assign empty      = (count == '0);
    assign req_ready  = (count != CW'(DEPTH));
    assign push       = req_valid && req_ready && !flush;
    assign pop        = !empty && (!wb_valid || wb_ready);
    assign fifo_count = count;

    assign add_fpop  = empty ? 1'b0  : mem_op[head];
    assign add_data1 = empty ? 32'h0 : mem_a[head];
    assign add_data2 = empty ? 32'h0 : mem_b[head];

    logic [31:0] op_a, op_b;
    logic [7:0]  ea, eb, er;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, wrap;
    logic [31:0] res_data;
    logic        res_nv, res_of;

    always_comb begin
        op_a   = add_data1;
        op_b   = {add_data2[31] ^ add_fpop, add_data2[30:0]};
        ea     = op_a[30:23];
        eb     = op_b[30:23];
        er     = add_result[30:23];
        a_nan  = (ea == 8'hFF) && (op_a[22:0] != '0);
        b_nan  = (eb == 8'hFF) && (op_b[22:0] != '0);
        a_inf  = (ea == 8'hFF) && (op_a[22:0] == '0);
        b_inf  = (eb == 8'hFF) && (op_b[22:0] == '0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        // Same-sign sum at the top binade must stay at FE or go to inf;
        // anything else means the adder's exponent wrapped.
        wrap   = (op_a[31] == op_b[31]) && ((ea == 8'hFE) || (eb == 8'hFE))
                 && (er != 8'hFE);
        res_data = add_result;
        res_nv   = 1'b0;
        res_of   = 1'b0;
        if (a_nan || b_nan) begin
            res_data = 32'h7FC00000;
            res_nv   = (a_nan && !op_a[22]) || (b_nan && !op_b[22]);
        end else if (a_inf && b_inf && (op_a[31] != op_b[31])) begin
            res_data = 32'h7FC00000;
            res_nv   = 1'b1;
        end else if (a_inf) begin
            res_data = op_a;
        end else if (b_inf) begin
            res_data = op_b;
        end else if (a_zero && b_zero) begin
            res_data = {op_a[31] & op_b[31], 31'h0};
        end else if (a_zero) begin
            res_data = op_b;
        end else if (b_zero) begin
            res_data = op_a;
        end else if ((op_a[30:0] == op_b[30:0]) && (op_a[31] != op_b[31])) begin
            res_data = 32'h0;
        end else if ((er == 8'hFF) || wrap) begin
            res_data = {add_result[31], 8'hFF, 23'h0};
            res_of   = 1'b1;
        end else if (er == 8'h00) begin
            res_data = {add_result[31], 31'h0};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[tail] <= req_op;
            mem_a[tail]  <= req_a;
            mem_b[tail]  <= req_b;
            mem_rd[tail] <= req_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_flags <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wb_valid <= 1'b0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (pop) begin
                wb_valid <= 1'b1;
                wb_rd    <= mem_rd[head];
                wb_data  <= res_data;
                wb_flags <= {res_nv, res_of};
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end
endmodule
